// File: rtl/bf_loop_ctrl_if.sv
// Handshake bundle between the fetch/decode stages and the loop controller.
// The fetch/decode side is the master; bf_loop_ctrl is the slave.
interface bf_loop_ctrl_if #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8
);
    logic               step_pc;
    logic [A_WIDTH-1:0] pc;
    logic               op_valid;
    logic [D_WIDTH-1:0] op;
    logic [A_WIDTH-1:0] op_pc;
    logic               dzero;
    logic               flush;
    logic               op_kill;
    logic               halt;

    modport master (
        output step_pc,
        output op_valid,
        output op,
        output op_pc,
        output dzero,
        input  pc,
        input  flush,
        input  op_kill,
        input  halt
    );

    modport slave (
        input  step_pc,
        input  op_valid,
        input  op,
        input  op_pc,
        input  dzero,
        output pc,
        output flush,
        output op_kill,
        output halt
    );
endinterface

// File: rtl/bf_loop_ctrl.sv
// Program-counter owner and [ / ] loop sequencer for the brainfuck pipeline.
// Backward jumps use a return stack of '[' addresses; loop skips use a
// depth-counting forward scan while the fetch stage keeps stepping.
module bf_loop_ctrl #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 16
) (
    input  logic         clk,
    input  logic         reset,
    bf_loop_ctrl_if.slave bus
);
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int IW  = SPW - 1;

    localparam logic [SPW-1:0]     SP_FULL  = SPW'(DEPTH);
    localparam logic [SPW-1:0]     SP_ONE   = SPW'(1);
    localparam logic [A_WIDTH-1:0] A_ONE    = A_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] OP_OPEN  = D_WIDTH'(8'h5B);
    localparam logic [D_WIDTH-1:0] OP_CLOSE = D_WIDTH'(8'h5D);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SKIP  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] pc_q;
    logic [A_WIDTH-1:0] stack_q [DEPTH];
    logic [SPW-1:0]     sp_q, sp_d;
    logic [A_WIDTH-1:0] depth_q, depth_d;

    logic               is_open;
    logic               is_close;
    logic               push;
    logic               redirect;
    logic               flush_c;
    logic               kill_c;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      top_idx;
    logic [A_WIDTH-1:0] top_addr;
    logic [A_WIDTH-1:0] target;

    assign is_open  = bus.op_valid && (bus.op == OP_OPEN);
    assign is_close = bus.op_valid && (bus.op == OP_CLOSE);

    // sp < DEPTH whenever a push happens, so its low bits address the free slot
    assign push_idx = sp_q[IW-1:0];
    assign top_idx  = IW'(sp_q - SP_ONE);
    assign top_addr = stack_q[top_idx];
    // Loop back to the instruction after the matching '['; wraps at the top
    assign target   = top_addr + A_ONE;

    // Next-state, stack-pointer, skip-depth and control-output decode
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        depth_d  = depth_q;
        push     = 1'b0;
        redirect = 1'b0;
        flush_c  = 1'b0;
        kill_c   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (is_open) begin
                    if (bus.dzero) begin
                        state_d = SKIP;
                        depth_d = A_ONE;
                    end else if (sp_q == SP_FULL) begin
                        state_d = FAULT;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_ONE;
                    end
                end else if (is_close) begin
                    if (sp_q == '0) begin
                        state_d = FAULT;
                    end else if (!bus.dzero) begin
                        redirect = 1'b1;
                        flush_c  = 1'b1;
                    end else begin
                        sp_d = sp_q - SP_ONE;
                    end
                end
            end

            SKIP: begin
                kill_c = 1'b1;
                if (is_open) begin
                    depth_d = depth_q + A_ONE;
                end else if (is_close) begin
                    if (depth_q == A_ONE) begin
                        state_d = RUN;
                        depth_d = '0;
                    end else begin
                        depth_d = depth_q - A_ONE;
                    end
                end
            end

            FAULT: begin
                kill_c = 1'b1;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control state, stack pointer and skip depth registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            sp_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

    // Program counter: redirect beats a same-cycle step; frozen once faulted
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (redirect) begin
            pc_q <= target;
        end else if (bus.step_pc && (state_q != FAULT)) begin
            pc_q <= pc_q + A_ONE;
        end
    end

    // Return stack storage; emptiness is tracked by sp alone
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= bus.op_pc;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.flush   = flush_c && !reset;
    assign bus.op_kill = kill_c && !reset;
    assign bus.halt    = (state_q == FAULT);
endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: a default-depth instance and a
// DEPTH=2 instance share one stimulus stream.
module tb_bf_loop_ctrl;
    localparam logic [7:0] OP_O = 8'h5B;
    localparam logic [7:0] OP_C = 8'h5D;
    localparam logic [7:0] OP_P = 8'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_pc;
    logic        op_valid;
    logic [7:0]  op;
    logic [11:0] op_pc;
    logic        dzero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [11:0] pc;
        logic        halt;
    } exp_t;

    exp_t sbq[$];

    bf_loop_ctrl_if #(.A_WIDTH(12), .D_WIDTH(8)) bus ();
    bf_loop_ctrl_if #(.A_WIDTH(12), .D_WIDTH(8)) bus2 ();

    assign bus.step_pc   = step_pc;
    assign bus.op_valid  = op_valid;
    assign bus.op        = op;
    assign bus.op_pc     = op_pc;
    assign bus.dzero     = dzero;
    assign bus2.step_pc  = step_pc;
    assign bus2.op_valid = op_valid;
    assign bus2.op       = op;
    assign bus2.op_pc    = op_pc;
    assign bus2.dzero    = dzero;

    bf_loop_ctrl #(.A_WIDTH(12), .D_WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bf_loop_ctrl #(.A_WIDTH(12), .D_WIDTH(8), .DEPTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: same-cycle flush/op_kill are checked before the
    // edge; the post-edge pc/halt expectation goes through the scoreboard.
    task automatic cyc(input string tag, input bit sel,
                       input logic st, input logic v, input logic [7:0] o,
                       input logic [11:0] opc, input logic dz,
                       input logic ef, input logic ek,
                       input logic [11:0] epc, input logic eh);
        exp_t e;
        exp_t got;
        step_pc  = st;
        op_valid = v;
        op       = o;
        op_pc    = opc;
        dzero    = dz;
        e.tag  = tag;
        e.sel  = sel;
        e.pc   = epc;
        e.halt = eh;
        sbq.push_back(e);
        #3;
        check({tag, ".flush"}, sel ? bus2.flush : bus.flush, ef);
        check({tag, ".kill"}, sel ? bus2.op_kill : bus.op_kill, ek);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check({got.tag, ".pc"}, got.sel ? bus2.pc : bus.pc, got.pc);
        check({got.tag, ".halt"}, got.sel ? bus2.halt : bus.halt, got.halt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        step_pc  = 1'b0;
        op_valid = 1'b0;
        op       = '0;
        op_pc    = '0;
        dzero    = 1'b0;
        @(posedge clk);
        #1;

        // Reset beats stepping, then five steps
        cyc("rst0", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        cyc("rst1", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++)
            cyc("step", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'(i), 0);

        // Backward jump: push 3, redirect to 4 beats step, then exit pops
        cyc("open3", 0, 1, 1, OP_O, 12'h003, 0, 0, 0, 12'h006, 0);
        cyc("close7", 0, 1, 1, OP_C, 12'h007, 0, 1, 0, 12'h004, 0);
        cyc("close7b", 0, 1, 1, OP_C, 12'h007, 0, 1, 0, 12'h004, 0);
        cyc("close_exit", 0, 1, 1, OP_C, 12'h007, 1, 0, 0, 12'h005, 0);

        // Nested skip: all four scanned ops killed, dzero ignored, PC steps
        cyc("skip_open", 0, 1, 1, OP_O, 12'h002, 1, 0, 0, 12'h006, 0);
        cyc("skip_in_open", 0, 1, 1, OP_O, 12'h003, 0, 0, 1, 12'h007, 0);
        cyc("skip_plus", 0, 1, 1, OP_P, 12'h004, 0, 0, 1, 12'h008, 0);
        cyc("skip_in_close", 0, 1, 1, OP_C, 12'h005, 0, 0, 1, 12'h009, 0);
        cyc("skip_end", 0, 1, 1, OP_C, 12'h006, 0, 0, 1, 12'h00A, 0);
        cyc("after_skip", 0, 1, 1, OP_P, 12'h007, 0, 0, 0, 12'h00B, 0);

        // Underflow: ']' on empty stack faults without flushing
        reset = 1'b1;
        cyc("rst_uf", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        reset = 1'b0;
        cyc("uf", 0, 0, 1, OP_C, 12'h000, 1, 0, 0, 12'h000, 1);
        cyc("uf_hold", 0, 1, 0, OP_P, 12'h000, 0, 0, 1, 12'h000, 1);
        reset = 1'b1;
        cyc("rst_fault", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        reset = 1'b0;

        // Overflow on the DEPTH=2 instance; the deep instance keeps running
        cyc("ov1", 1, 1, 1, OP_O, 12'h000, 0, 0, 0, 12'h001, 0);
        cyc("ov2", 1, 1, 1, OP_O, 12'h001, 0, 0, 0, 12'h002, 0);
        cyc("ov3", 1, 1, 1, OP_O, 12'h002, 0, 0, 0, 12'h003, 1);
        cyc("ov_frozen", 1, 1, 0, OP_P, 12'h000, 0, 0, 1, 12'h003, 1);
        check("deep.pc", bus.pc, 12'h004);
        check("deep.halt", bus.halt, 1'b0);

        // Reset in the middle of a depth-3 skip
        reset = 1'b1;
        cyc("rst_ov", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        check("small.halt_rst", bus2.halt, 1'b0);
        reset = 1'b0;
        cyc("s3_a", 0, 1, 1, OP_O, 12'h000, 1, 0, 0, 12'h001, 0);
        cyc("s3_b", 0, 1, 1, OP_O, 12'h001, 1, 0, 1, 12'h002, 0);
        cyc("s3_c", 0, 1, 1, OP_O, 12'h002, 1, 0, 1, 12'h003, 0);
        reset = 1'b1;
        cyc("rst_skip", 0, 1, 0, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);
        reset = 1'b0;
        cyc("post_rst", 0, 0, 1, OP_P, 12'h000, 0, 0, 0, 12'h000, 0);

        // Wrap: stacked 0xFFF redirects to 0x000; stack then holds exactly one
        cyc("wrap_open", 0, 1, 1, OP_O, 12'hFFF, 0, 0, 0, 12'h001, 0);
        cyc("wrap_close", 0, 1, 1, OP_C, 12'h001, 0, 1, 0, 12'h000, 0);
        cyc("wrap_pop", 0, 0, 1, OP_C, 12'h001, 1, 0, 0, 12'h000, 0);
        cyc("wrap_empty", 0, 0, 1, OP_C, 12'h001, 1, 0, 0, 12'h000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bf_loop_ctrl.md
# bf_loop_ctrl

Program-counter owner and loop sequencer for the brainfuck pipeline. It holds PC, advances it on the fetch stage's `step_pc`, and handles `[`/`]` control flow. A return stack implements backward jumps. A depth-counting forward scan implements loop skips. It issues `flush` and `op_kill` so the fetch/decode stages discard wrong-path opcodes.

## Interface

- `A_WIDTH`, 12, PC / instruction address width.
- `D_WIDTH`, 8, opcode width.
- `DEPTH`, 16, loop stack entries (power of two, ≥2).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `step_pc` in 1: fetch stage fetches this cycle; PC increments at next edge.
- `pc` out A_WIDTH: current instruction address, to fetch stage.
- `op_valid` in 1: decoded opcode presented this cycle.
- `op` in D_WIDTH: opcode; `[` = 0x5B, `]` = 0x5D, all others are non-control.
- `op_pc` in A_WIDTH: address the opcode was fetched from.
- `dzero` in 1: current data cell is zero; valid with `op_valid`.
- `flush` out 1: combinational; fetch/decode stages drop all in-flight opcodes this cycle.
- `op_kill` out 1: combinational; the opcode presented this cycle must not execute.
- `halt` out 1: registered sticky fault (stack overflow or underflow).

## Operation

- **States:**
  - `RUN`: normal execution.
  - `SKIP`: forward scan for the matching `]`.
  - `FAULT`: stopped.
- **Registers:**
  - `pc`.
  - stack[DEPTH] of A_WIDTH.
  - `sp`, $clog_2$(DEPTH)+1 bits; 0 = empty.
  - `depth`, A_WIDTH bits.
  - state.
- **PC update priority:** reset → 0; else redirect → target; else `step_pc` and state≠FAULT → pc+1 (wraps modulo 2^A_WIDTH); else hold.
- **In RUN with `op_valid`:**
  - `[` with dzero=0, sp<DEPTH: stack[sp] ← op_pc, sp+1.
  - `[` with dzero=0, sp==DEPTH: go to FAULT.
  - `[` with dzero=1: go to SKIP, depth ← 1. No stack change, no flush.
  - `]` with dzero=0, sp>0: redirect target = stack[sp-1]+1 (wrapping); `flush`=1; sp unchanged.
  - `]` with dzero=1, sp>0: pop (sp-1); no redirect.
  - `]` with sp==0: go to FAULT, whatever `dzero` is.
  - Other opcodes: no action.
- **In SKIP:**
  - `op_kill`=1 every cycle, including the cycle the terminating `]` is presented.
  - With `op_valid`: `[` → depth+1. `]` with depth==1 → RUN, depth ← 0. `]` otherwise → depth-1.
  - `dzero` ignored; stack untouched; PC keeps stepping.
- **FAULT:** `halt`=1; PC frozen; `op_kill`=1; `flush`=0; leaves only on reset.
- **Ops in the flush cycle:** an op presented with `op_valid` in a cycle where `flush`=1 is the redirecting `]` itself. The next op this block acts on is the first one fetched from the new PC.

## Timing

- **Reset values:** pc=0, sp=0, depth=0, state=RUN, `halt`=0. `flush`=0 and `op_kill`=0 while reset=1 (both gated with !reset).
- **Redirect:** `flush` is asserted in the same cycle `]` is accepted; `pc` shows the target at the following edge. The fetch stage's first fetch from the target occurs one cycle after `flush`.
- **Simultaneous redirect and `step_pc`:** redirect wins; the increment is discarded.
- **SKIP entry:** `op_kill` rises at the edge after the `[` is accepted, and falls at the edge after the matching `]` is accepted.
- **Reset mid-SKIP or mid-FAULT:** next cycle state=RUN, `op_kill`=0, stack empty, pc=0.
- **Wrap:** stack[top]=2^A_WIDTH−1 gives target 0.

## Test plan

1. **Reset and stepping:** reset 2 cycles → pc=0, `halt`=0, `op_kill`=0. Then `step_pc`=1 for 5 cycles → pc=5.
2. **Backward jump:**
   - `[` op_pc=3 dzero=0 → sp=1.
   - `]` op_pc=7 dzero=0 → `flush`=1 that cycle, pc=4 next cycle (even with `step_pc`=1), sp=1.
   - `]` dzero=1 → no flush, sp=0.
3. **Nested skip:** `[` op_pc=2 dzero=1, then ops `[`, `+`, `]`, `]` → `op_kill`=1 on all four, state RUN after the last `]`, pc increments throughout, sp unchanged.
4. **Overflow:** DEPTH=2, three `[` dzero=0 → `halt`=1 after the third; pc frozen under `step_pc`=1; `op_kill`=1.
5. **Underflow:** after reset, `]` dzero=1 → `halt`=1 next cycle, no flush.
6. **Reset mid-SKIP and wrap:**
   - Reset during SKIP with depth=3 → RUN, `op_kill`=0, pc=0.
   - `[` op_pc=0xFFF then `]` dzero=0 → pc=0x000.
